// File: rtl/cr_xp10_decomp_pkg.sv
// Shared definitions for the XP10 decompressor CRC control block.
//   crc_state_e    : frame-tracking FSM states
//   CRC32C_POLY    : reflected CRC32C (Castagnoli) polynomial
//   CRC32C_SEED    : running-CRC initial value
//   CRC32C_FIN_XOR : XOR applied to the running CRC to form the final CRC
package cr_xp10_decomp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESULT = 2'd2
  } crc_state_e;

  localparam logic [31:0] CRC32C_POLY    = 32'h82F6_3B78;
  localparam logic [31:0] CRC32C_SEED    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32C_FIN_XOR = 32'hFFFF_FFFF;

endpackage

// File: rtl/cr_xp10_decomp_crc_ctl_if.sv
// Beat-in / result-out bundle for cr_xp10_decomp_crc_ctl.
//   in_*  : 64-bit payload beat stream with sof/eof framing and expected CRC
//   out_* : one registered result per frame (CRC32C + mismatch flag)
// master = beat producer / result consumer, slave = the CRC control block.
interface cr_xp10_decomp_crc_ctl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic        in_eof;
  logic [63:0] in_data;
  logic [6:0]  in_data_sz;
  logic [31:0] in_exp_crc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_crc;
  logic        out_mismatch;

  modport master (
    output in_valid, in_sof, in_eof, in_data, in_data_sz, in_exp_crc, out_ready,
    input  in_ready, out_valid, out_crc, out_mismatch
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_data, in_data_sz, in_exp_crc, out_ready,
    output in_ready, out_valid, out_crc, out_mismatch
  );
endinterface

// File: rtl/cr_xp10_decomp_crc32c_step.sv
// Combinational CRC32C update over one beat.
//   crc_in  : running (non-inverted) CRC
//   data    : beat payload, byte 0 in [7:0], consumed LSB-first
//   data_sz : valid bits, 0..64 in multiples of 8 (caller filters illegal sizes)
//   crc_out : running CRC after data_sz/8 bytes
module cr_xp10_decomp_crc32c_step
  import cr_xp10_decomp_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [6:0]  data_sz,
  output logic [31:0] crc_out
);

  logic [3:0] n_bytes;
  assign n_bytes = data_sz[6:3];

  always_comb begin
    crc_out = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < n_bytes) begin
        crc_out = crc_out ^ {24'h0, data[8*b +: 8]};
        for (int k = 0; k < 8; k++)
          crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32C_POLY) : (crc_out >> 1);
      end
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_crc_ctl.sv
// Per-frame CRC32C checker for the XP10 decompressor output stream.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : beat input (in_*) and frame result output (out_*)
//   proto_err      : sticky flag for framing / size violations
//   proto_err_clr  : clears proto_err (a same-cycle set wins)
// Optional feature: define CR_XP10_DECOMP_CRC_CHK_EN to register in_exp_crc on
// the eof beat and compare it with the final CRC; otherwise out_mismatch is 0.
module cr_xp10_decomp_crc_ctl
  import cr_xp10_decomp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  cr_xp10_decomp_crc_ctl_if.slave   bus,
  output logic                      proto_err,
  input  logic                      proto_err_clr
);

  crc_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] out_crc_q, out_crc_d;
  logic        perr_set;
  logic        accept, sz_bad, load_res;
  logic [31:0] crc_base, step_crc, beat_crc;

  assign bus.in_ready  = (state_q != ST_RESULT);
  assign bus.out_valid = (state_q == ST_RESULT);
  assign bus.out_crc   = out_crc_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign sz_bad = (bus.in_data_sz > 7'd64) || (bus.in_data_sz[2:0] != 3'd0);

  // A sof beat always starts from the seed, whether or not a frame was open.
  assign crc_base = bus.in_sof ? CRC32C_SEED : crc_q;
  // Illegal-size beats still frame the packet but contribute no bytes.
  assign beat_crc = sz_bad ? crc_base : step_crc;

  cr_xp10_decomp_crc32c_step u_step (
    .crc_in  (crc_base),
    .data    (bus.in_data),
    .data_sz (bus.in_data_sz),
    .crc_out (step_crc)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    out_crc_d = out_crc_q;
    perr_set  = 1'b0;
    load_res  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sz_bad) perr_set = 1'b1;
          if (bus.in_sof) begin
            crc_d    = beat_crc;
            state_d  = bus.in_eof ? ST_RESULT : ST_ACTIVE;
            load_res = bus.in_eof;
          end else begin
            perr_set = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          if (sz_bad || bus.in_sof) perr_set = 1'b1;
          crc_d    = beat_crc;
          state_d  = bus.in_eof ? ST_RESULT : ST_ACTIVE;
          load_res = bus.in_eof;
        end
      end
      ST_RESULT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_res) out_crc_d = beat_crc ^ CRC32C_FIN_XOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC32C_SEED;
      out_crc_q <= 32'h0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      out_crc_q <= out_crc_d;
      if (perr_set)           proto_err <= 1'b1;
      else if (proto_err_clr) proto_err <= 1'b0;
    end
  end

`ifdef CR_XP10_DECOMP_CRC_CHK_EN
  logic [31:0] exp_crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        exp_crc_q <= 32'h0;
    else if (load_res) exp_crc_q <= bus.in_exp_crc;
  end

  // Both operands are registered, so the flag is stable for the whole result.
  assign bus.out_mismatch = (out_crc_q != exp_crc_q);
`else
  assign bus.out_mismatch = 1'b0;
`endif

endmodule
